// File: rtl/jsv_sched_pkg.sv
// Shared types and constants for the Julia set frame scheduler.
// Coordinates are signed Q4.28 fixed point.
package jsv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int COORD_W_DEF = 32;
    localparam int FRAC_BITS   = 28;
    localparam int INT_BITS    = COORD_W_DEF - FRAC_BITS;
    localparam int CNT_W_DEF   = 10;

endpackage

// File: rtl/jsv_axis_stepper.sv
// One screen axis: pixel counter plus a coordinate accumulator that
// steps up or down from a shadowed origin by a shadowed step.
module jsv_axis_stepper #(
    parameter int CNT_W   = 10,
    parameter int COORD_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic               wrap,
    input  logic               dir_sub,
    input  logic [COORD_W-1:0] origin,
    input  logic [COORD_W-1:0] step,
    output logic [CNT_W-1:0]   count,
    output logic [COORD_W-1:0] coord
);

    logic [COORD_W-1:0] base;
    logic [COORD_W-1:0] delta;

    // Viewport shadow and running position; wrap returns to the shadowed origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
            coord <= {COORD_W{1'b0}};
            base  <= {COORD_W{1'b0}};
            delta <= {COORD_W{1'b0}};
        end else if (load) begin
            count <= {CNT_W{1'b0}};
            coord <= origin;
            base  <= origin;
            delta <= step;
        end else if (advance) begin
            if (wrap) begin
                count <= {CNT_W{1'b0}};
                coord <= base;
            end else begin
                count <= count + CNT_W'(1);
                coord <= dir_sub ? (coord - delta) : (coord + delta);
            end
        end
    end

endmodule

// File: rtl/jsv_frame_scheduler.sv
// Walks every pixel of a frame in raster order, issuing one valid/ready
// request per pixel with the initial z and the c latched at frame start.
module jsv_frame_scheduler
    import jsv_sched_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] c_real_in,
    input  logic [COORD_W-1:0] c_imag_in,
    input  logic [COORD_W-1:0] x_origin_in,
    input  logic [COORD_W-1:0] y_origin_in,
    input  logic [COORD_W-1:0] step_in,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [CNT_W-1:0]   px_x,
    output logic [CNT_W-1:0]   px_y,
    output logic [COORD_W-1:0] z_real,
    output logic [COORD_W-1:0] z_imag,
    output logic [COORD_W-1:0] c_real,
    output logic [COORD_W-1:0] c_imag,
    output logic               busy,
    output logic               done
);

    sched_state_t state;
    logic load;
    logic xfer;
    logic x_last;
    logic y_last;
    logic frame_end;
    logic advance_x;
    logic advance_y;

    // Abort outranks a same-cycle transfer, so the steppers never move on abort.
    assign load      = (state == LOAD);
    assign xfer      = (state == ISSUE) && px_valid && px_ready && !abort;
    assign x_last    = (px_x == CNT_W'(H_RES - 1));
    assign y_last    = (px_y == CNT_W'(V_RES - 1));
    assign frame_end = x_last && y_last;
    assign advance_x = xfer && !frame_end;
    assign advance_y = advance_x && x_last;

    jsv_axis_stepper #(.CNT_W(CNT_W), .COORD_W(COORD_W)) u_x_axis (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance_x),
        .wrap    (x_last),
        .dir_sub (1'b0),
        .origin  (x_origin_in),
        .step    (step_in),
        .count   (px_x),
        .coord   (z_real)
    );

    // Imaginary axis decreases down the screen and never wraps within a frame.
    jsv_axis_stepper #(.CNT_W(CNT_W), .COORD_W(COORD_W)) u_y_axis (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance_y),
        .wrap    (1'b0),
        .dir_sub (1'b1),
        .origin  (y_origin_in),
        .step    (step_in),
        .count   (px_y),
        .coord   (z_imag)
    );

    // Frame sequencing with registered valid, busy and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            px_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= ISSUE;
                        px_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state    <= IDLE;
                        px_valid <= 1'b0;
                        busy     <= 1'b0;
                    end else if (xfer && frame_end) begin
                        state    <= DONE;
                        px_valid <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    px_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // c is captured only in LOAD so PIO writes mid-frame cannot tear a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_real <= {COORD_W{1'b0}};
            c_imag <= {COORD_W{1'b0}};
        end else if (load) begin
            c_real <= c_real_in;
            c_imag <= c_imag_in;
        end
    end

endmodule

// File: tb/tb_jsv_frame_scheduler.sv
// Directed self-checking bench for jsv_frame_scheduler on a 4x3 frame.
module tb_jsv_frame_scheduler;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int NP = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] c_real_in, c_imag_in, x_origin_in, y_origin_in, step_in;
    logic        px_valid, px_ready, busy, done;
    logic [9:0]  px_x, px_y;
    logic [31:0] z_real, z_imag, c_real, c_imag;
    logic [83:0] payload;

    int tests = 0;
    int fails = 0;

    int nxfer, nbad, ndone, nstall_bad, c_bad, first_cyc, last_cyc, done_cyc;
    bit aborted, timed_out;
    logic [31:0] xo, yo, st, exp_c;
    logic [31:0] rec_zr [NP];
    logic [31:0] rec_zi [NP];

    jsv_frame_scheduler #(.H_RES(H), .V_RES(V), .CNT_W(10), .COORD_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .c_real_in   (c_real_in),
        .c_imag_in   (c_imag_in),
        .x_origin_in (x_origin_in),
        .y_origin_in (y_origin_in),
        .step_in     (step_in),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_x        (px_x),
        .px_y        (px_y),
        .z_real      (z_real),
        .z_imag      (z_imag),
        .c_real      (c_real),
        .c_imag      (c_imag),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    assign payload = {px_x, px_y, z_real, z_imag};

    task automatic set_view(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] s);
        xo = x0; yo = y0; st = s;
        x_origin_in = x0; y_origin_in = y0; step_in = s;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Drives one frame from the LOAD cycle onward and records what it saw.
    task automatic run_frame(input int mode, input int abort_at, input int start_at,
                             input int c_at, input int max_cyc);
        logic [83:0] prev_pl;
        logic [83:0] exp_pl;
        logic        prev_stall;
        logic        rdy;
        int          ex, ey;
        nxfer = 0; nbad = 0; ndone = 0; nstall_bad = 0; c_bad = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        aborted = 1'b0; timed_out = 1'b1;
        prev_stall = 1'b0; prev_pl = '0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            px_ready = rdy;
            if ((px_valid || done) && (c_real !== exp_c)) c_bad++;
            if (prev_stall && (!px_valid || payload !== prev_pl)) nstall_bad++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                if (px_valid) nbad++;
                timed_out = 1'b0;
                break;
            end
            if (px_valid && rdy) begin
                if (nxfer == abort_at) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                    timed_out = 1'b0;
                    break;
                end
                ex = nxfer % H;
                ey = nxfer / H;
                exp_pl = {10'(ex), 10'(ey), xo + st * 32'(ex), yo - st * 32'(ey)};
                if (nxfer >= NP || payload !== exp_pl) nbad++;
                if (nxfer < NP) begin
                    rec_zr[nxfer] = z_real;
                    rec_zi[nxfer] = z_imag;
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nxfer++;
                if (nxfer == start_at) start = 1'b1;
                if (nxfer == c_at) begin
                    c_real_in = 32'h0040_0000;
                    step_in   = 32'h0000_0007;
                end
            end
            prev_stall = px_valid && !rdy;
            prev_pl    = payload;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({px_valid, busy, done, px_x, px_y, z_real, z_imag, c_real, c_imag} !== 151'd0) begin
            fails++;
            $display("FAIL reset_values: got valid=%b busy=%b done=%b x=%0d y=%0d zr=%h zi=%h cr=%h ci=%h expected all 0",
                     px_valid, busy, done, px_x, px_y, z_real, z_imag, c_real, c_imag);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({px_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: got valid/busy/done=%b expected 000", {px_valid, busy, done});
        end
    endtask

    task automatic test_basic();
        set_view(32'hF000_0000, 32'h1000_0000, 32'h0100_0000);
        c_real_in = 32'hA5A5_0001; c_imag_in = 32'h5A5A_0002; exp_c = 32'hA5A5_0001;
        pulse_start();
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, px_valid} !== 2'b10) begin
            fails++;
            $display("FAIL load_cycle: got busy/valid=%b expected 10", {busy, px_valid});
        end
        run_frame(0, -1, -1, -1, 200);
        tests++;
        if (timed_out || nxfer != NP || nbad != 0) begin
            fails++;
            $display("FAIL basic_frame: got xfers=%0d bad=%0d timeout=%0d expected 12/0/0", nxfer, nbad, timed_out);
        end
        tests++;
        if (rec_zr[3] !== 32'hF300_0000 || rec_zi[8] !== 32'h0E00_0000) begin
            fails++;
            $display("FAIL basic_corners: got zr(3,0)=%h zi(0,2)=%h expected f3000000 0e000000", rec_zr[3], rec_zi[8]);
        end
        tests++;
        if (ndone != 1 || done_cyc != last_cyc + 1 || last_cyc - first_cyc != NP - 1) begin
            fails++;
            $display("FAIL basic_timing: got done=%0d done_cyc=%0d last=%0d first=%0d expected 1, last+1, span 11",
                     ndone, done_cyc, last_cyc, first_cyc);
        end
        tests++;
        if (c_real !== 32'hA5A5_0001 || c_imag !== 32'h5A5A_0002) begin
            fails++;
            $display("FAIL basic_c: got %h %h expected a5a50001 5a5a0002", c_real, c_imag);
        end
        @(negedge clk);
        tests++;
        if ({busy, done, px_valid} !== 3'b000) begin
            fails++;
            $display("FAIL basic_idle: got busy/done/valid=%b expected 000", {busy, done, px_valid});
        end
    endtask

    task automatic test_backpressure();
        set_view(32'h0000_0000, 32'h0000_0000, 32'h0000_0100);
        pulse_start();
        run_frame(1, -1, -1, -1, 300);
        tests++;
        if (timed_out || nxfer != NP || nbad != 0 || nstall_bad != 0 || ndone != 1) begin
            fails++;
            $display("FAIL backpressure: got xfers=%0d bad=%0d stall_bad=%0d done=%0d expected 12/0/0/1",
                     nxfer, nbad, nstall_bad, ndone);
        end
    endtask

    task automatic test_c_change();
        set_view(32'h1000_0000, 32'hF800_0000, 32'h0020_0000);
        c_real_in = 32'h1234_5678; exp_c = 32'h1234_5678;
        pulse_start();
        run_frame(0, -1, -1, 5, 200);
        tests++;
        if (timed_out || c_bad != 0 || nbad != 0 || ndone != 1 || c_real !== 32'h1234_5678) begin
            fails++;
            $display("FAIL c_hold: got c_bad=%0d bad=%0d done=%0d c_real=%h expected 0/0/1 12345678",
                     c_bad, nbad, ndone, c_real);
        end
        step_in = st;
        exp_c = 32'h0040_0000;
        pulse_start();
        run_frame(0, -1, -1, -1, 200);
        tests++;
        if (timed_out || c_bad != 0 || ndone != 1 || c_real !== 32'h0040_0000) begin
            fails++;
            $display("FAIL c_next_frame: got c_bad=%0d done=%0d c_real=%h expected 0/1 00400000",
                     c_bad, ndone, c_real);
        end
    endtask

    task automatic test_abort();
        int late;
        set_view(32'hF000_0000, 32'h1000_0000, 32'h0100_0000);
        pulse_start();
        run_frame(0, 6, -1, -1, 200);
        tests++;
        if (!aborted || nxfer != 6 || nbad != 0) begin
            fails++;
            $display("FAIL abort_reach: got aborted=%0d xfers=%0d bad=%0d expected 1/6/0", aborted, nxfer, nbad);
        end
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if ({px_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL abort_idle: got valid/busy/done=%b expected 000", {px_valid, busy, done});
        end
        late = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || px_valid) late++;
        end
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", late);
        end
        pulse_start();
        run_frame(0, -1, -1, -1, 200);
        tests++;
        if (timed_out || nxfer != NP || nbad != 0 || ndone != 1) begin
            fails++;
            $display("FAIL abort_rerun: got xfers=%0d bad=%0d done=%0d expected 12/0/1", nxfer, nbad, ndone);
        end
    endtask

    task automatic test_start_busy();
        int extra;
        pulse_start();
        run_frame(0, -1, 3, -1, 200);
        tests++;
        if (timed_out || nxfer != NP || nbad != 0 || ndone != 1) begin
            fails++;
            $display("FAIL start_busy: got xfers=%0d bad=%0d done=%0d expected 12/0/1", nxfer, nbad, ndone);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done || px_valid) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL start_busy_queued: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        run_frame(0, -1, -1, -1, 200);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || ndone != 1) begin
            fails++;
            $display("FAIL b2b_idle: got busy=%b done_count=%0d expected 0/1", busy, ndone);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        run_frame(0, -1, -1, -1, 200);
        tests++;
        if (timed_out || nxfer != NP || nbad != 0 || ndone != 1) begin
            fails++;
            $display("FAIL b2b_frame: got xfers=%0d bad=%0d done=%0d expected 12/0/1", nxfer, nbad, ndone);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        @(negedge clk);
        start = 1'b0;
        px_ready = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (px_valid !== 1'b1 || px_x === 10'd0) begin
            fails++;
            $display("FAIL reset_mid_pre: got valid=%b x=%0d expected 1 and x!=0", px_valid, px_x);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({px_valid, busy, done, px_x, px_y, z_real, z_imag, c_real, c_imag} !== 151'd0) begin
            fails++;
            $display("FAIL reset_mid: got valid=%b busy=%b x=%0d y=%0d zr=%h zi=%h cr=%h expected all 0",
                     px_valid, busy, px_x, px_y, z_real, z_imag, c_real);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_c = c_real_in;
        pulse_start();
        run_frame(0, -1, -1, -1, 200);
        tests++;
        if (timed_out || nxfer != NP || nbad != 0 || ndone != 1 || c_bad != 0) begin
            fails++;
            $display("FAIL reset_rerun: got xfers=%0d bad=%0d done=%0d c_bad=%0d expected 12/0/1/0",
                     nxfer, nbad, ndone, c_bad);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b0;
        c_real_in = 32'h0; c_imag_in = 32'h0;
        set_view(32'h0, 32'h0, 32'h0);
        exp_c = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_c_change();
        test_abort();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
